// File: rtl/aes_pkg.sv
// Shared AES types and constants: key-expansion FSM states, round-constant
// endpoints and small GF(2^8) / word helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    STREAM  = 2'd2
  } key_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_LAST = 8'h6c;
  localparam logic [3:0] LAST_IDX  = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Exact inverse of xtime: undo the reduction when the low bit shows it happened.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Key-in / round-key-out handshake bundle for aes_key_expansion.
// The expansion block is the slave; the key source and round-key consumer are the master.
`include "aes_defines.svh"

interface aes_key_expansion_if;
  logic                       key_valid;
  logic                       key_ready;
  logic [`AES_BLOCK_SIZE-1:0] key;
  logic                       enc;
  logic                       rk_valid;
  logic                       rk_ready;
  logic [`AES_BLOCK_SIZE-1:0] rk;
  logic [3:0]                 rk_idx;
  logic                       rk_last;

  modport master (
    output key_valid, key, enc, rk_ready,
    input  key_ready, rk_valid, rk, rk_idx, rk_last
  );

  modport slave (
    input  key_valid, key, enc, rk_ready,
    output key_ready, rk_valid, rk, rk_idx, rk_last
  );
endinterface

// File: rtl/aes_defines.svh
// Shared size and word-slicing macros for the AES key path.
// Word 0 is the most significant 32 bits of a 128-bit block.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES_BLOCK_SIZE 128
`define AES_WORD_SIZE  32
`define AES_1ST_WORD   127:96
`define AES_2ND_WORD   95:64
`define AES_3RD_WORD   63:32
`define AES_4TH_WORD   31:0

`endif

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational: multiplicative inverse in GF(2^8)
// followed by the affine transform.
import aes_pkg::*;

module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ acc;
      acc = xtime(acc);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv     = gf_inv(byte_val);
    sub_val = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 round-key generator streaming round keys 0..10 over a valid/ready bus.
// Define AES_KEY_DEC_ORDER_EN to add the enc input, PRECOMP phase and 10..0 streaming.
`include "aes_defines.svh"

module aes_key_expansion
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  aes_key_expansion_if.slave  bus
);

  key_state_t                 state, state_next;
  logic [`AES_BLOCK_SIZE-1:0] w_q, w_next;
  logic [7:0]                 rcon_q, rcon_next;
  logic [3:0]                 idx_q, idx_next;
  logic [3:0]                 last_idx;
  logic                       rk_last_w;

  logic [`AES_WORD_SIZE-1:0]  w0, w1, w2, w3;
  logic [`AES_WORD_SIZE-1:0]  sub_in, sub_out;
  logic [`AES_WORD_SIZE-1:0]  w0_f, w1_f, w2_f, w3_f;
  logic [`AES_BLOCK_SIZE-1:0] fwd_key, step_key;
  logic [7:0]                 fwd_rcon, step_rcon;
  logic [3:0]                 step_idx;

  assign w0 = w_q[`AES_1ST_WORD];
  assign w1 = w_q[`AES_2ND_WORD];
  assign w2 = w_q[`AES_3RD_WORD];
  assign w3 = w_q[`AES_4TH_WORD];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_val (sub_in[8*g +: 8]),
      .sub_val  (sub_out[8*g +: 8])
    );
  end

  assign w0_f     = w0 ^ sub_out ^ {rcon_q, 24'h0};
  assign w1_f     = w1 ^ w0_f;
  assign w2_f     = w2 ^ w1_f;
  assign w3_f     = w3 ^ w2_f;
  assign fwd_key  = {w0_f, w1_f, w2_f, w3_f};
  assign fwd_rcon = xtime(rcon_q);

`ifdef AES_KEY_DEC_ORDER_EN
  logic                       enc_q, enc_next;
  logic                       rev_sel;
  logic [7:0]                 rev_rcon;
  logic [`AES_WORD_SIZE-1:0]  w0_r, w1_r, w2_r, w3_r;

  // The reverse step recovers the previous w3 first, so the shared S-boxes
  // see RotWord(w3 ^ w2) instead of RotWord(w3) when walking backwards.
  assign rev_sel   = (state == STREAM) && !enc_q;
  assign w3_r      = w3 ^ w2;
  assign w2_r      = w2 ^ w1;
  assign w1_r      = w1 ^ w0;
  assign rev_rcon  = inv_xtime(rcon_q);
  assign w0_r      = w0 ^ sub_out ^ {rev_rcon, 24'h0};
  assign sub_in    = rot_word(rev_sel ? w3_r : w3);
  assign step_key  = rev_sel ? {w0_r, w1_r, w2_r, w3_r} : fwd_key;
  assign step_rcon = rev_sel ? rev_rcon : fwd_rcon;
  assign step_idx  = rev_sel ? (idx_q - 4'd1) : (idx_q + 4'd1);
  assign last_idx  = enc_q ? LAST_IDX : 4'd0;
`else
  assign sub_in    = rot_word(w3);
  assign step_key  = fwd_key;
  assign step_rcon = fwd_rcon;
  assign step_idx  = idx_q + 4'd1;
  assign last_idx  = LAST_IDX;
`endif

  assign rk_last_w     = (state == STREAM) && (idx_q == last_idx);
  assign bus.key_ready = (state == IDLE);
  assign bus.rk_valid  = (state == STREAM);
  assign bus.rk        = w_q;
  assign bus.rk_idx    = idx_q;
  assign bus.rk_last   = rk_last_w;

  // The last handshake returns to IDLE without stepping, so a key offered
  // in that same cycle waits until key_ready is seen high.
  always_comb begin
    state_next = state;
    w_next     = w_q;
    rcon_next  = rcon_q;
    idx_next   = idx_q;
`ifdef AES_KEY_DEC_ORDER_EN
    enc_next   = enc_q;
`endif
    case (state)
      IDLE: begin
        if (bus.key_valid) begin
          w_next    = bus.key;
          rcon_next = RCON_INIT;
          idx_next  = 4'd0;
`ifdef AES_KEY_DEC_ORDER_EN
          enc_next   = bus.enc;
          state_next = bus.enc ? STREAM : PRECOMP;
`else
          state_next = STREAM;
`endif
        end
      end
`ifdef AES_KEY_DEC_ORDER_EN
      PRECOMP: begin
        w_next    = fwd_key;
        rcon_next = fwd_rcon;
        idx_next  = idx_q + 4'd1;
        if (idx_q == LAST_IDX - 4'd1) state_next = STREAM;
      end
`endif
      STREAM: begin
        if (bus.rk_ready) begin
          if (rk_last_w) begin
            state_next = IDLE;
          end else begin
            w_next    = step_key;
            rcon_next = step_rcon;
            idx_next  = step_idx;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      w_q    <= '0;
      rcon_q <= RCON_INIT;
      idx_q  <= 4'd0;
`ifdef AES_KEY_DEC_ORDER_EN
      enc_q  <= 1'b1;
`endif
    end else begin
      state  <= state_next;
      w_q    <= w_next;
      rcon_q <= rcon_next;
      idx_q  <= idx_next;
`ifdef AES_KEY_DEC_ORDER_EN
      enc_q  <= enc_next;
`endif
    end
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: known-answer table, random keys with
// backpressure, mid-sequence reset and busy-key cases against a word-array key schedule.
module tb_aes_key_expansion;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

`ifdef AES_KEY_DEC_ORDER_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  typedef struct {
    logic [127:0] key;
    logic         enc;
    int           gap;
    logic [127:0] rk0;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vec_count   = 0;
  int   miscompares = 0;

  logic [7:0]   sbox_tbl [256];
  logic [127:0] model_rk [11];
  logic [127:0] got_rk   [11];

  always #5 clk = ~clk;

  aes_key_expansion_if bus ();

  aes_key_expansion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook 44-word schedule; round key r is words 4r..4r+3.
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_key_ready"}, bus.key_ready, 1'b1);
    check_output({tag, "_rk_valid"},  bus.rk_valid,  1'b0);
    check_output({tag, "_rk_last"},   bus.rk_last,   1'b0);
    check_output({tag, "_rk_idx"},    bus.rk_idx,    4'd0);
    check_output({tag, "_rk"},        bus.rk,        128'h0);
  endtask

  // Called at a negedge with the key bus idle; returns one negedge after acceptance.
  task automatic apply_stimulus(input logic [127:0] k, input logic e);
    int waited;
    waited = 0;
    bus.key       = k;
    bus.enc       = e;
    bus.key_valid = 1'b1;
    while (!bus.key_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_output("accept_key_ready", bus.key_ready, 1'b1);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Entered one negedge after key acceptance; leaves at the negedge after the last handshake.
  task automatic stream_check(input logic [127:0] k, input logic e, input int gap);
    int           lat, n, budget;
    bit           fwd;
    logic [3:0]   exp_idx;
    logic         rdy, stalled;
    logic [127:0] held_rk;
    logic [3:0]   held_idx;
    build_model(k);
    for (int r = 0; r < 11; r++) got_rk[r] = '0;
    fwd = !(DEC_EN && !e);
    lat = 1;
    while (!bus.rk_valid && lat < 40) begin
      check_output("busy_key_ready", bus.key_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check_output("latency", lat, fwd ? 1 : 11);
    n = 0;
    budget = 0;
    stalled = 1'b0;
    held_rk = '0;
    held_idx = '0;
    while (n < 11 && budget < 400) begin
      exp_idx = fwd ? 4'(n) : 4'(10 - n);
      if (!bus.rk_valid) begin
        check_output("rk_valid", bus.rk_valid, 1'b1);
        break;
      end
      if (stalled) begin
        check_output("stall_rk", bus.rk, held_rk);
        check_output("stall_idx", bus.rk_idx, held_idx);
      end
      check_output("rk_idx", bus.rk_idx, exp_idx);
      check_output("rk", bus.rk, model_rk[exp_idx]);
      check_output("rk_last", bus.rk_last, n == 10);
      got_rk[exp_idx] = bus.rk;
      rdy = ($urandom_range(0, 99) >= gap);
      bus.rk_ready = rdy;
      held_rk  = bus.rk;
      held_idx = bus.rk_idx;
      @(negedge clk);
      budget++;
      if (rdy) n++;
      stalled = !rdy;
    end
    check_output("handshakes", n, 11);
    bus.rk_ready = 1'b0;
    check_output("idle_key_ready", bus.key_ready, 1'b1);
    check_output("idle_rk_valid", bus.rk_valid, 1'b0);
  endtask

  initial begin
    vec_t         vecs [6];
    logic [127:0] ka, kb;
    int           waited;

    build_sbox();
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.enc       = 1'b0;
    bus.rk_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset");

    vecs[0] = '{FIPS_KEY, 1'b1, 0,  FIPS_KEY, FIPS_RK1, FIPS_RK10};
    vecs[1] = '{FIPS_KEY, 1'b0, 0,  FIPS_KEY, FIPS_RK1, FIPS_RK10};
    vecs[2] = '{FIPS_KEY, 1'b1, 40, FIPS_KEY, FIPS_RK1, FIPS_RK10};
    vecs[3] = '{FIPS_KEY, 1'b0, 30, FIPS_KEY, FIPS_RK1, FIPS_RK10};
    for (int i = 4; i < 6; i++) begin
      ka = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_model(ka);
      vecs[i] = '{ka, 1'(i - 4), 25, model_rk[0], model_rk[1], model_rk[10]};
    end

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].key, vecs[i].enc);
      stream_check(vecs[i].key, vecs[i].enc, vecs[i].gap);
      check_output($sformatf("vec%0d_rk0", i),  got_rk[0],  vecs[i].rk0);
      check_output($sformatf("vec%0d_rk1", i),  got_rk[1],  vecs[i].rk1);
      check_output($sformatf("vec%0d_rk10", i), got_rk[10], vecs[i].rk10);
    end

    for (int i = 0; i < 8; i++) begin
      ka = {$urandom(), $urandom(), $urandom(), $urandom()};
      apply_stimulus(ka, 1'($urandom_range(0, 1)));
      stream_check(ka, bus.enc, int'($urandom_range(0, 50)));
    end

    // Reset while round key 5 is on the bus, then a fresh key must start at round 0.
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    apply_stimulus(ka, 1'b1);
    bus.rk_ready = 1'b1;
    waited = 0;
    while (bus.rk_idx != 4'd5 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    bus.rk_ready = 1'b0;
    check_output("mid_idx", bus.rk_idx, 4'd5);
    #1 rst = 1'b1;
    #1 check_reset_state("mid_stream_reset");
    @(negedge clk);
    rst = 1'b0;
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    apply_stimulus(kb, 1'b1);
    stream_check(kb, 1'b1, 0);

    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    apply_stimulus(ka, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_state("early_reset");
    @(negedge clk);
    rst = 1'b0;

    // Second key held valid during the first stream is taken only after the last handshake.
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.key       = ka;
    bus.enc       = 1'b1;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key = kb;
    stream_check(ka, 1'b1, 20);
    @(negedge clk);
    bus.key_valid = 1'b0;
    stream_check(kb, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

Interface
REQ-001 The block SHALL have no parameters; key length is fixed at 128 bits (`AES_BLOCK_SIZE).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port key_valid, input, 1 bit: a cipher key is offered.
REQ-005 The block SHALL have port key_ready, output, 1 bit: the block accepts a key.
REQ-006 The block SHALL have port key, input, 128 bits: cipher key; byte 0 at bits [127:120], word 0 = `AES_1ST_WORD.
REQ-007 The block SHALL have port enc, input, 1 bit: key order, sampled with the key; 1 = rounds 0..10, 0 = rounds 10..0.
REQ-008 The block SHALL have port rk_valid, output, 1 bit: a round key is presented.
REQ-009 The block SHALL have port rk_ready, input, 1 bit: the round-key consumer (AddRoundKey stage) accepts.
REQ-010 The block SHALL have port rk, output, 128 bits: current round key, same byte order as key.
REQ-011 The block SHALL have port rk_idx, output, 4 bits: round number of rk (0..10).
REQ-012 The block SHALL have port rk_last, output, 1 bit: high with rk_valid on the final key of the sequence.

Function
REQ-013 The block SHALL implement FSM states IDLE, PRECOMP and STREAM, with key_ready = (state == IDLE).
REQ-014 The block SHALL, in IDLE on key_valid & key_ready, load key into the working register, set rcon = 8'h01 and rk_idx = 0, latch enc, and go to STREAM if enc=1, else PRECOMP.
REQ-015 The forward step SHALL be: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2', rcon' = xtime(rcon), rk_idx' = rk_idx+1; RotWord{a,b,c,d} = {b,c,d,a}.
REQ-016 The block SHALL, in PRECOMP, apply one forward step per cycle for exactly 10 cycles with rk_valid=0, then enter STREAM with rk_idx=10 and rcon=8'h6c.
REQ-017 The reverse step SHALL be: rcon' = inv_xtime(rcon) (rcon[0] ? ((rcon^8'h1b)>>1)|8'h80 : rcon>>1), w3' = w3^w2, w2' = w2^w1, w1' = w1^w0, w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon',24'h0}, rk_idx' = rk_idx-1.
REQ-018 The block SHALL, in STREAM, drive rk_valid=1 and rk = the working register; on rk_valid & rk_ready it SHALL apply a forward (enc) or reverse (dec) step.
REQ-019 rk_last SHALL be 1 iff in STREAM and rk_idx == (enc ? 10 : 0); the handshake on that key SHALL return the FSM to IDLE without stepping.
REQ-020 rk, rk_idx and rk_last SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-021 Latency SHALL be: key accepted in cycle N gives rk_valid in cycle N+1 (enc) or N+11 (dec); a full enc sequence with rk_ready tied high occupies 11 cycles.
REQ-022 Because key_ready=0 outside IDLE, key_valid asserted during PRECOMP/STREAM SHALL be ignored; a key offered in the same cycle as the last handshake SHALL be accepted no earlier than the next cycle.
REQ-023 rk_valid, rk_idx and rk_last SHALL never be X after reset; rk SHALL reflect the working register in every state.

Reset
REQ-024 rst SHALL force state=IDLE, key_ready=1, rk_valid=0, rk_last=0, rk_idx=0, rcon=8'h01 and rk=128'h0 immediately, including mid-PRECOMP or mid-STREAM; the partial sequence SHALL be discarded.

Configuration
REQ-025 Macro AES_KEY_DEC_ORDER_EN defined: enc, PRECOMP and the reverse step SHALL be present as specified.
REQ-026 Macro AES_KEY_DEC_ORDER_EN undefined: enc SHALL be ignored, PRECOMP and the reverse-step logic SHALL be absent, and keys SHALL always stream 0..10.

Structure
REQ-027 Word slicing and size constants SHALL come from aes_defines.svh (`AES_WORD_SIZE, `AES_1ST_WORD..`AES_4TH_WORD); the FSM state enum and RCON_INIT/RCON_LAST constants SHALL live in shared package aes_pkg.
REQ-028 SubWord SHALL use four instances of sub-module aes_sbox (forward S-box, 8-bit combinational), shared by the forward and reverse steps.

Verification
REQ-029 Enc stream: key 2b7e151628aed2a6abf7158809cf4f3c, enc=1, rk_ready=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, key_ready=1 the next cycle.
REQ-030 Dec stream: same key, enc=0 -> rk_valid rises at N+11 with idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; idx1 = a0fafe17...; idx0 = 2b7e1516... with rk_last=1.
REQ-031 Backpressure: random rk_ready gaps -> rk/rk_idx stable during stalls, and the sequence is identical to REQ-029.
REQ-032 Reset mid-stream: rst pulsed at idx5 -> rk_valid=0 and key_ready=1 in the same cycle; a new key then restarts at idx0.
REQ-033 Busy key ignore: key_valid held with a second key during STREAM -> the second key is accepted only after the first sequence's rk_last handshake.
REQ-034 Macro off: enc=0 -> forward order per REQ-029 and no 10-cycle delay.
